// File: rtl/inst_fetch_stage.sv
// IF stage: owns the PC, issues one SRAM-style fetch at a time and fills the F/D slot.
// Handles decode stalls, branch delay slots, CP0 flushes and misaligned-PC (AdEL) fetches.
module inst_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_d,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic        valid_d,
    output logic        adel_d,
    output logic        fetch_stall
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc_f;
    logic [31:0] tgt_pc;
    logic        tgt_pend;
    logic        discard;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic        hold_adel;

    logic        misaligned;
    logic        word_vld;
    logic [31:0] word_instr;
    logic        can_load;
    logic        take_hold;
    logic        advance;
    logic        outstanding;
    logic [31:0] seq_pc;

    assign misaligned  = pc_f[1:0] != 2'b00;
    assign inst_req    = !rst && state == S_REQ && !misaligned;
    assign inst_addr   = pc_f;
    assign fetch_stall = !valid_d;

    always_comb begin
        word_vld    = 1'b0;
        word_instr  = misaligned ? 32'd0 : inst_rdata;
        can_load    = !stall_d || !valid_d;
        take_hold   = state == S_HOLD && !stall_d;
        outstanding = 1'b0;
        seq_pc      = pc_f + 32'd4;
        if (state == S_REQ)
            word_vld = misaligned || (inst_addr_ok && inst_data_ok);
        else if (state == S_WAIT)
            word_vld = inst_data_ok && !discard;
        advance = (word_vld && can_load) || take_hold;
        // A request still in flight after this edge must have its data dropped
        if (state == S_WAIT && !inst_data_ok)
            outstanding = 1'b1;
        else if (inst_req && inst_addr_ok && !inst_data_ok)
            outstanding = 1'b1;
        // A redirect arriving as the delay slot lands steers the very next fetch
        if (redirect)
            seq_pc = redirect_pc;
        else if (tgt_pend)
            seq_pc = tgt_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pc_f       <= RESET_PC;
            tgt_pc     <= 32'd0;
            tgt_pend   <= 1'b0;
            discard    <= 1'b0;
            instr_d    <= 32'd0;
            pc_d       <= 32'd0;
            valid_d    <= 1'b0;
            adel_d     <= 1'b0;
            hold_instr <= 32'd0;
            hold_pc    <= 32'd0;
            hold_adel  <= 1'b0;
        end else if (flush) begin
            pc_f     <= flush_pc;
            tgt_pend <= 1'b0;
            valid_d  <= 1'b0;
            discard  <= outstanding;
            state    <= outstanding ? S_WAIT : S_REQ;
        end else begin
            if (advance) begin
                pc_f     <= seq_pc;
                tgt_pend <= 1'b0;
            end else if (redirect) begin
                tgt_pc   <= redirect_pc;
                tgt_pend <= 1'b1;
            end

            if (advance) begin
                instr_d <= take_hold ? hold_instr : word_instr;
                pc_d    <= take_hold ? hold_pc : pc_f;
                adel_d  <= take_hold ? hold_adel : misaligned;
                valid_d <= 1'b1;
            end else if (!stall_d) begin
                valid_d <= 1'b0;
            end

            if (word_vld && !can_load) begin
                hold_instr <= word_instr;
                hold_pc    <= pc_f;
                hold_adel  <= misaligned;
            end

            unique case (state)
                S_REQ: begin
                    if (word_vld)
                        state <= can_load ? S_REQ : S_HOLD;
                    else if (inst_req && inst_addr_ok)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        discard <= 1'b0;
                        state   <= (discard || can_load) ? S_REQ : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall_d)
                        state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Bench for inst_fetch_stage: SRAM-like slave model plus address and
// delivery scoreboards, one task per scenario.
module tb_inst_fetch_stage;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] EXC_PC = 32'hBFC0_0380;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_d = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'd0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = 32'd0;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        valid_d;
    logic        adel_d;
    logic        fetch_stall;

    int checks = 0;
    int errors = 0;
    int lat = 0;

    slot_t       exp_q[$];
    logic [31:0] exp_addr[$];
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'd0;

    inst_fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .stall_d(stall_d),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .flush(flush), .flush_pc(flush_pc),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d),
        .adel_d(adel_d), .fetch_stall(fetch_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic slot_t mk(input logic [31:0] pc);
        slot_t s;
        s.pc = pc;
        s.instr = mem(pc);
        s.adel = 1'b0;
        return s;
    endfunction

    // Slave + monitor: sample at negedge, drive at posedge+1
    initial begin
        bit          s_rst, acc, dok;
        logic [31:0] a, ea;
        slot_t       e;
        forever begin
            @(negedge clk);
            s_rst = rst;
            acc = inst_req && inst_addr_ok;
            dok = inst_data_ok;
            a = inst_addr;
            if (!rst && valid_d && !stall_d) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_instr: pc_d=%h instr_d=%h adel=%b, none expected",
                             pc_d, instr_d, adel_d);
                end else begin
                    e = exp_q.pop_front();
                    if ({pc_d, instr_d, adel_d} !== {e.pc, e.instr, e.adel}) begin
                        errors++;
                        $display("FAIL slot: got pc=%h instr=%h adel=%b want pc=%h instr=%h adel=%b",
                                 pc_d, instr_d, adel_d, e.pc, e.instr, e.adel);
                    end
                end
            end
            if (acc) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("FAIL extra_req: addr=%h, none expected", a);
                end else begin
                    ea = exp_addr.pop_front();
                    if (a !== ea) begin
                        errors++;
                        $display("FAIL fetch_addr: got %h want %h", a, ea);
                    end
                end
            end
            @(posedge clk);
            #1;
            if (s_rst) begin
                pend = 1'b0;
            end else begin
                if (dok) pend = 1'b0;
                if (acc && !dok) begin
                    pend = 1'b1;
                    paddr = a;
                    cnt = lat;
                end
            end
            inst_addr_ok = 1'b0;
            inst_data_ok = 1'b0;
            inst_rdata = 32'hDEAD_BEEF;
            if (rst) begin
                inst_addr_ok = 1'b0;
            end else if (pend) begin
                cnt--;
                if (cnt <= 0) begin
                    inst_data_ok = 1'b1;
                    inst_rdata = mem(paddr);
                end
            end else if (inst_req && exp_addr.size() > 0) begin
                inst_addr_ok = 1'b1;
                if (lat == 0) begin
                    inst_data_ok = 1'b1;
                    inst_rdata = mem(inst_addr);
                end
            end
        end
    end

    task automatic do_reset(input int l);
        @(posedge clk);
        #1;
        rst = 1'b1;
        stall_d = 1'b0;
        redirect = 1'b0;
        flush = 1'b0;
        lat = l;
        exp_q.delete();
        exp_addr.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_slot(input logic [31:0] pc, output bit found);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (valid_d && pc_d == pc) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && exp_addr.size() == 0 && !pend) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (inst_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: got %b want 0", inst_req);
        end
        checks++;
        if (inst_addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_addr: got %h want %h", inst_addr, RST_PC);
        end
        checks++;
        if ({valid_d, adel_d, fetch_stall} !== 3'b001) begin
            errors++;
            $display("FAIL reset_flags: got valid/adel/stall=%b want 001",
                     {valid_d, adel_d, fetch_stall});
        end
        checks++;
        if ({instr_d, pc_d} !== 64'd0) begin
            errors++;
            $display("FAIL reset_slot: got instr=%h pc=%h want 0", instr_d, pc_d);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        bit ok;
        do_reset(0);
        for (int i = 0; i < 3; i++) begin
            exp_addr.push_back(RST_PC + 32'(4 * i));
            exp_q.push_back(mk(RST_PC + 32'(4 * i)));
        end
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL zero_wait_drain: left %0d slots %0d addrs want 0",
                     exp_q.size(), exp_addr.size());
        end
        checks++;
        if (fetch_stall !== 1'b1) begin
            errors++;
            $display("FAIL zero_wait_idle_stall: got %b want 1", fetch_stall);
        end
    endtask

    task automatic test_wait_latency();
        int waits = 0;
        int bad = 0;
        do_reset(3);
        exp_addr.push_back(RST_PC);
        exp_addr.push_back(RST_PC + 32'd4);
        exp_q.push_back(mk(RST_PC));
        exp_q.push_back(mk(RST_PC + 32'd4));
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (pend && !inst_data_ok) begin
                waits++;
                if (inst_req !== 1'b0 || fetch_stall !== 1'b1) bad++;
            end
            if (exp_q.size() == 0 && !pend) break;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wait_req_low: %0d wait cycles with req/fetch_stall wrong, want 0", bad);
        end
        checks++;
        if (waits != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wait_cycles: got %0d waits %0d left want 4 waits 0 left",
                     waits, exp_q.size());
        end
    endtask

    task automatic test_branch();
        bit ok;
        logic [31:0] seq[4];
        seq[0] = RST_PC;
        seq[1] = RST_PC + 32'd4;
        seq[2] = 32'hBFC0_0100;
        seq[3] = 32'hBFC0_0104;
        for (int l = 0; l < 2; l++) begin
            do_reset(l);
            for (int i = 0; i < 4; i++) begin
                exp_addr.push_back(seq[i]);
                exp_q.push_back(mk(seq[i]));
            end
            wait_slot(RST_PC, ok);
            redirect = 1'b1;
            redirect_pc = 32'hBFC0_0100;
            @(posedge clk);
            #1;
            redirect = 1'b0;
            drain(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL branch_lat%0d: left %0d slots %0d addrs want 0",
                         l, exp_q.size(), exp_addr.size());
            end
        end
    endtask

    task automatic test_flush();
        bit ok;
        for (int w = 0; w < 2; w++) begin
            do_reset(3);
            exp_addr.push_back(RST_PC);
            exp_addr.push_back(RST_PC + 32'd4);
            exp_addr.push_back(EXC_PC);
            exp_q.push_back(mk(RST_PC));
            exp_q.push_back(mk(EXC_PC));
            ok = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (pend && paddr == RST_PC + 32'd4 && !inst_data_ok) begin
                    ok = 1'b1;
                    break;
                end
            end
            flush = 1'b1;
            flush_pc = EXC_PC;
            redirect = w[0];
            redirect_pc = 32'hBFC0_0200;
            @(posedge clk);
            #1;
            flush = 1'b0;
            redirect = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL flush_setup%0d: wait state not reached", w);
            end
            drain(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL flush_drain%0d: left %0d slots %0d addrs want 0",
                         w, exp_q.size(), exp_addr.size());
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        int bad = 0;
        do_reset(0);
        stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_addr.push_back(RST_PC + 32'(4 * i));
            exp_q.push_back(mk(RST_PC + 32'(4 * i)));
        end
        wait_slot(RST_PC, ok);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (pc_d !== RST_PC || instr_d !== mem(RST_PC) || valid_d !== 1'b1 ||
                inst_req !== 1'b0)
                bad++;
        end
        checks++;
        if (!ok || bad != 0) begin
            errors++;
            $display("FAIL stall_hold: found=%b unstable=%0d want found=1 unstable=0", ok, bad);
        end
        @(posedge clk);
        #1;
        stall_d = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pc_d !== RST_PC + 32'd4 || valid_d !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got pc=%h valid=%b want %h 1",
                     pc_d, valid_d, RST_PC + 32'd4);
        end
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_drain: left %0d slots %0d addrs want 0",
                     exp_q.size(), exp_addr.size());
        end
    endtask

    task automatic test_adel();
        bit ok;
        logic [31:0] bad_pc = 32'hBFC0_0102;
        do_reset(0);
        exp_addr.push_back(RST_PC);
        exp_addr.push_back(RST_PC + 32'd4);
        exp_q.push_back(mk(RST_PC));
        exp_q.push_back(mk(RST_PC + 32'd4));
        wait_slot(RST_PC, ok);
        redirect = 1'b1;
        redirect_pc = bad_pc;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        wait_slot(RST_PC + 32'd4, ok);
        checks++;
        if (!ok || inst_addr !== bad_pc || inst_req !== 1'b0) begin
            errors++;
            $display("FAIL adel_no_req: found=%b addr=%h req=%b want 1 %h 0",
                     ok, inst_addr, inst_req, bad_pc);
        end
        @(posedge clk);
        #1;
        stall_d = 1'b1;
        @(negedge clk);
        checks++;
        if ({pc_d, instr_d, adel_d, valid_d} !== {bad_pc, 32'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL adel_slot: got pc=%h instr=%h adel=%b valid=%b want %h 0 1 1",
                     pc_d, instr_d, adel_d, valid_d, bad_pc);
        end
        @(posedge clk);
        #1;
        flush = 1'b1;
        flush_pc = EXC_PC;
        exp_addr.push_back(EXC_PC);
        exp_q.push_back(mk(EXC_PC));
        @(posedge clk);
        #1;
        flush = 1'b0;
        stall_d = 1'b0;
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL adel_drain: left %0d slots %0d addrs want 0",
                     exp_q.size(), exp_addr.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_latency();
        test_branch();
        test_flush();
        test_stall();
        test_adel();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
